// File: rtl/measure_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// measure_sweep_ctrl_if
// Wishbone slave bundle for the delay-sweep measurement controller.
// Signals keep their slave-side names (_i = into the controller, _o = out).
//   wb_cyc_i/wb_stb_i/wb_we_i : bus cycle, strobe, write enable
//   wb_adr_i                  : byte address (only [3:2] decoded)
//   wb_dat_i / wb_dat_o       : write / read data
//   wb_sel_i                  : byte selects (full-word access only)
//   wb_ack_o                  : acknowledge, one cycle after the request
//   wb_stall_o                : never stalls
// -----------------------------------------------------------------------------
interface measure_sweep_ctrl_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_stall_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_stall_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_stall_o
    );
endinterface

// File: rtl/measure_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// measure_sweep_ctrl
// Sweeps a delay code from start_code to stop_code in increments of step.
// At every code it waits for the delay lines to settle, fires `shots` strobes,
// counts comparator hits and pushes {code, hits} into a result FIFO that the
// host drains through the RESULT register.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   wb                 : Wishbone slave (CTRL / RANGE / CFG / RESULT)
//   delay_code_o       : code driven onto both delay lines
//   stb_req_o          : one-cycle request to the strobe generator
//   stb_done_i, cmp_i  : strobe completion pulse and comparator result
//   busy_o, irq_o      : sweep running; DONE/ERR interrupt (level)
// -----------------------------------------------------------------------------
module measure_sweep_ctrl #(
    parameter int CODE_W        = 10,
    parameter int CNT_W         = 16,
    parameter int FIFO_DEPTH    = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int STB_TIMEOUT   = 1024
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    measure_sweep_ctrl_if.slave  wb,
    output logic [CODE_W-1:0]    delay_code_o,
    output logic                 stb_req_o,
    input  logic                 stb_done_i,
    input  logic                 cmp_i,
    output logic                 busy_o,
    output logic                 irq_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_FIRE, S_WAIT, S_STORE, S_NEXT
    } state_t;

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int SW   = $clog2(SETTLE_CYCLES + 1);
    localparam int TW   = $clog2(STB_TIMEOUT + 1);
    localparam int EW   = CODE_W + CNT_W;
    // Wide enough for code+step without losing the carry.
    localparam int SUMW = ((CODE_W > 8) ? CODE_W : 8) + 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(STB_TIMEOUT - 1);
    localparam logic [AW:0]   DEPTH_C     = (AW + 1)'(FIFO_DEPTH);

    state_t state_q, state_d;

    // ---------------- bus decode ----------------
    logic       acc, wr_acc, rd_acc;
    logic [1:0] reg_sel;
    logic       wr_ctrl, start_req, abort_req, clr_req;

    assign acc       = wb.wb_cyc_i & wb.wb_stb_i;
    assign wr_acc    = acc & wb.wb_we_i;
    assign rd_acc    = acc & ~wb.wb_we_i;
    assign reg_sel   = wb.wb_adr_i[3:2];
    assign wr_ctrl   = wr_acc && (reg_sel == 2'd0);
    assign start_req = wr_ctrl & wb.wb_dat_i[0];
    assign abort_req = wr_ctrl & wb.wb_dat_i[1];
    assign clr_req   = wr_ctrl & wb.wb_dat_i[2];

    // Byte selects and upper address bits are intentionally not decoded.
    logic unused_ok;
    assign unused_ok = ^{wb.wb_sel_i, wb.wb_adr_i, wb.wb_dat_i};

    // ---------------- registers / datapath state ----------------
    logic [CODE_W-1:0] start_code_q, stop_code_q, code_q;
    logic [CNT_W-1:0]  shots_q, shot_q, hit_q;
    logic [7:0]        step_q;
    logic              irq_en_q, done_q, err_q;
    logic [SW-1:0]     settle_q;
    logic [TW-1:0]     wait_q;

    logic [CNT_W-1:0]  shots_eff;
    logic [7:0]        step_eff;
    logic [CNT_W:0]    shot_nxt;
    logic [SUMW-1:0]   code_sum;
    logic              sum_over;

    assign shots_eff = (shots_q == '0) ? CNT_W'(1) : shots_q;
    assign step_eff  = (step_q  == '0) ? 8'd1      : step_q;
    assign shot_nxt  = {1'b0, shot_q} + (CNT_W + 1)'(1);
    assign code_sum  = SUMW'(code_q) + SUMW'(step_eff);
    assign sum_over  = code_sum > SUMW'(stop_code_q);

    // ---------------- result FIFO ----------------
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          fifo_empty, fifo_full, push, pop;
    logic [EW-1:0] rd_entry;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign pop        = rd_acc && (reg_sel == 2'd3) && !fifo_empty;
    assign rd_entry   = fifo_mem[rd_ptr_q];

    // ---------------- FSM next state ----------------
    logic start_ok, done_set, err_set;

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        done_set = 1'b0;
        err_set  = 1'b0;
        push     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_req && !abort_req) begin
                    start_ok = 1'b1;
                    if (start_code_q > stop_code_q) done_set = 1'b1;
                    else                            state_d  = S_SETTLE;
                end
            end
            S_SETTLE: if (settle_q == SETTLE_LAST) state_d = S_FIRE;
            S_FIRE:   state_d = S_WAIT;
            S_WAIT: begin
                if (stb_done_i) begin
                    state_d = (shot_nxt < {1'b0, shots_eff}) ? S_FIRE : S_STORE;
                end else if (wait_q == TO_LAST) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_STORE: begin
                // Hold here while the FIFO is full so no result is dropped.
                if (!fifo_full) begin
                    push    = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (sum_over) begin
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d  = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything: no flag, no push, straight to IDLE.
        if (abort_req) begin
            state_d  = S_IDLE;
            done_set = 1'b0;
            err_set  = 1'b0;
            push     = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- read mux ----------------
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0: rdata[5:0] = {fifo_full, fifo_empty, irq_en_q, err_q, done_q, busy_o};
            2'd1: begin
                rdata[CODE_W-1:0]  = start_code_q;
                rdata[16+:CODE_W]  = stop_code_q;
            end
            2'd2: begin
                rdata[CNT_W-1:0]   = shots_q;
                rdata[23:16]       = step_q;
            end
            default: begin
                if (!fifo_empty) begin
                    rdata[31]         = 1'b1;
                    rdata[16+:CODE_W] = rd_entry[CNT_W+:CODE_W];
                    rdata[CNT_W-1:0]  = rd_entry[CNT_W-1:0];
                end
            end
        endcase
    end

    // ---------------- sequential datapath ----------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb.wb_ack_o  <= 1'b0;
            wb.wb_dat_o  <= '0;
            start_code_q <= '0;
            stop_code_q  <= '0;
            shots_q      <= '0;
            step_q       <= '0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= '0;
            settle_q     <= '0;
            wait_q       <= '0;
            shot_q       <= '0;
            hit_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            wb.wb_ack_o <= acc;
            wb.wb_dat_o <= rd_acc ? rdata : 32'd0;

            // Sweep setup is frozen while a sweep runs.
            if (wr_acc && reg_sel == 2'd1 && state_q == S_IDLE) begin
                start_code_q <= wb.wb_dat_i[CODE_W-1:0];
                stop_code_q  <= wb.wb_dat_i[16+:CODE_W];
            end
            if (wr_acc && reg_sel == 2'd2 && state_q == S_IDLE) begin
                shots_q <= wb.wb_dat_i[CNT_W-1:0];
                step_q  <= wb.wb_dat_i[23:16];
            end
            if (wr_ctrl) irq_en_q <= wb.wb_dat_i[3];

            // Clear first, set last: a flag raised this cycle wins.
            if (clr_req || start_ok) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (done_set) done_q <= 1'b1;
            if (err_set)  err_q  <= 1'b1;

            if (start_ok && !done_set)
                code_q <= start_code_q;
            else if (state_q == S_NEXT && !abort_req && !sum_over)
                code_q <= code_sum[CODE_W-1:0];

            settle_q <= (state_q == S_SETTLE) ? settle_q + SW'(1) : '0;
            wait_q   <= (state_q == S_WAIT)   ? wait_q + TW'(1)   : '0;

            if (state_q == S_SETTLE) begin
                shot_q <= '0;
                hit_q  <= '0;
            end else if (state_q == S_WAIT && stb_done_i) begin
                shot_q <= shot_nxt[CNT_W-1:0];
                if (cmp_i && hit_q != '1) hit_q <= hit_q + CNT_W'(1);
            end

            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push && !wb_rst_i) fifo_mem[wr_ptr_q] <= {code_q, hit_q};
    end

    assign wb.wb_stall_o = 1'b0;
    assign delay_code_o  = code_q;
    assign stb_req_o     = (state_q == S_FIRE);
    assign busy_o        = (state_q != S_IDLE);
    assign irq_o         = irq_en_q & (done_q | err_q);

endmodule

// File: tb/tb_measure_sweep_ctrl.sv
module tb_measure_sweep_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    measure_sweep_ctrl_if wb();

    logic [9:0] delay_code;
    logic       stb_req, stb_done, cmp, busy, irq;

    measure_sweep_ctrl #(
        .CODE_W(10), .CNT_W(16), .FIFO_DEPTH(4),
        .SETTLE_CYCLES(8), .STB_TIMEOUT(1024)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wb           (wb),
        .delay_code_o (delay_code),
        .stb_req_o    (stb_req),
        .stb_done_i   (stb_done),
        .cmp_i        (cmp),
        .busy_o       (busy),
        .irq_o        (irq)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          req_cnt  = 0;
    bit          stb_en   = 1'b1;
    logic        cmp_val  = 1'b1;
    logic [31:0] rd;
    bit          ok;
    int          r0;

    // Strobe generator model: counts requests, answers one cycle later.
    initial begin
        stb_done = 1'b0;
        cmp      = 1'b0;
        forever begin
            @(negedge clk);
            if (stb_req === 1'b1) begin
                req_cnt++;
                if (stb_en) begin
                    @(posedge clk); #1;
                    stb_done = 1'b1;
                    cmp      = cmp_val;
                    @(posedge clk); #1;
                    stb_done = 1'b0;
                    cmp      = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Bus drivers; entered and left 1 time unit after a rising edge.
    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
        wb.wb_adr_i = adr;  wb.wb_dat_i = dat;  wb.wb_sel_i = 4'hf;
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = adr;  wb.wb_sel_i = 4'hf;
        @(posedge clk); #1;
        dat = wb.wb_dat_o;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit done);
        done = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (busy === 1'b0) begin done = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_code(input logic [9:0] code, input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (delay_code === code) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({delay_code, stb_req, busy, irq, wb.wb_ack_o} !== 14'd0 || wb.wb_dat_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: code=%h req=%b busy=%b irq=%b ack=%b dat=%h, all must be 0",
                     delay_code, stb_req, busy, irq, wb.wb_ack_o, wb.wb_dat_o);
        end
        rst = 1'b0;
        wb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h10) begin n_fail++; $display("FAIL reset_ctrl: got %h exp %h", rd, 32'h10); end
        n_checks++;
        if (wb.wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL reset_ack: got %b exp 1", wb.wb_ack_o); end
        wb_read(32'h4, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_range: got %h exp 0", rd); end
        wb_read(32'h8, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_cfg: got %h exp 0", rd); end
    endtask

    task automatic test_basic_sweep;
        wb_write(32'h4, 32'h0004_0002);
        wb_write(32'h8, 32'h0001_0003);
        cmp_val = 1'b1; stb_en = 1'b1;
        r0 = req_cnt;
        wb_write(32'h0, 32'h1);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b exp 1", busy); end
        wait_idle(500, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: busy still %b, exp 0", busy); end
        n_checks++;
        if (req_cnt - r0 !== 9) begin n_fail++; $display("FAIL basic_pulses: got %0d exp 9", req_cnt - r0); end
        wb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h02) begin n_fail++; $display("FAIL basic_ctrl: got %h exp %h", rd, 32'h02); end
        wb_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'h8002_0003) begin n_fail++; $display("FAIL basic_res0: got %h exp %h", rd, 32'h80020003); end
        wb_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'h8003_0003) begin n_fail++; $display("FAIL basic_res1: got %h exp %h", rd, 32'h80030003); end
        wb_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'h8004_0003) begin n_fail++; $display("FAIL basic_res2: got %h exp %h", rd, 32'h80040003); end
        wb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h12) begin n_fail++; $display("FAIL basic_ctrl_drained: got %h exp %h", rd, 32'h12); end
    endtask

    task automatic test_top_range;
        wb_write(32'h4, 32'h03FF_03FC);
        wb_write(32'h8, 32'h0008_0001);
        cmp_val = 1'b0;
        r0 = req_cnt;
        wb_write(32'h0, 32'h1);
        wait_idle(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL top_timeout: busy still %b, exp 0", busy); end
        n_checks++;
        if (req_cnt - r0 !== 1) begin n_fail++; $display("FAIL top_pulses: got %0d exp 1", req_cnt - r0); end
        wb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h02) begin n_fail++; $display("FAIL top_ctrl: got %h exp %h", rd, 32'h02); end
        wb_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'h83FC_0000) begin n_fail++; $display("FAIL top_res: got %h exp %h", rd, 32'h83FC0000); end
        wb_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL top_no_wrap: got %h exp 0", rd); end
        n_checks++;
        if (delay_code !== 10'd1020) begin n_fail++; $display("FAIL top_code_hold: got %0d exp 1020", delay_code); end
    endtask

    task automatic test_timeout;
        stb_en = 1'b0;
        wb_write(32'h4, 32'h0000_0000);
        wb_write(32'h8, 32'h0001_0001);
        r0 = req_cnt;
        wb_write(32'h0, 32'h9);
        // 8 settle + 1 fire + 1024 wait cycles: still busy at 1032, idle at 1033.
        repeat (1032) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early: busy=%b exp 1", busy); end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_late: busy=%b exp 0", busy); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL timeout_irq: got %b exp 1", irq); end
        n_checks++;
        if (req_cnt - r0 !== 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d exp 1", req_cnt - r0); end
        wb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h1C) begin n_fail++; $display("FAIL timeout_ctrl: got %h exp %h", rd, 32'h1C); end
        wb_write(32'h0, 32'hC);
        wb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h18) begin n_fail++; $display("FAIL clr_flags: got %h exp %h", rd, 32'h18); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL clr_irq: got %b exp 0", irq); end
        wb_write(32'h0, 32'h0);
        stb_en = 1'b1;
    endtask

    task automatic test_backpressure;
        wb_write(32'h4, 32'h000F_000A);
        wb_write(32'h8, 32'h0001_0001);
        cmp_val = 1'b1;
        r0 = req_cnt;
        wb_write(32'h0, 32'h1);
        repeat (150) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_hold_busy: got %b exp 1", busy); end
        wb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h21) begin n_fail++; $display("FAIL bp_ctrl_full: got %h exp %h", rd, 32'h21); end
        wb_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'h800A_0001) begin n_fail++; $display("FAIL bp_res10: got %h exp %h", rd, 32'h800A0001); end
        wb_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'h800B_0001) begin n_fail++; $display("FAIL bp_res11: got %h exp %h", rd, 32'h800B0001); end
        wait_idle(300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_timeout: busy still %b, exp 0", busy); end
        n_checks++;
        if (req_cnt - r0 !== 6) begin n_fail++; $display("FAIL bp_pulses: got %0d exp 6", req_cnt - r0); end
        wb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h22) begin n_fail++; $display("FAIL bp_ctrl_done: got %h exp %h", rd, 32'h22); end
        for (int k = 12; k <= 15; k++) begin
            wb_read(32'hC, rd);
            n_checks++;
            if (rd !== (32'h8000_0001 | (k << 16))) begin
                n_fail++;
                $display("FAIL bp_res%0d: got %h exp %h", k, rd, 32'h80000001 | (k << 16));
            end
        end
    endtask

    task automatic test_abort;
        wb_write(32'h4, 32'h001E_0014);
        wb_write(32'h8, 32'h0001_0001);
        cmp_val = 1'b1;
        wb_write(32'h0, 32'h1);
        wait_code(10'd21, 100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL abort_step2: code=%0d exp 21", delay_code); end
        stb_en = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        wb_write(32'h0, 32'h2);
        n_checks++;
        if (busy !== 1'b0 || stb_req !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: busy=%b req=%b exp 0 0", busy, stb_req);
        end
        r0 = req_cnt;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (req_cnt !== r0) begin n_fail++; $display("FAIL abort_quiet: got %0d pulses exp 0", req_cnt - r0); end
        wb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h00) begin n_fail++; $display("FAIL abort_ctrl: got %h exp 0", rd); end
        wb_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'h8014_0001) begin n_fail++; $display("FAIL abort_res: got %h exp %h", rd, 32'h80140001); end
        wb_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL empty_read: got %h exp 0", rd); end
        stb_en = 1'b1;
    endtask

    task automatic test_inverted_and_restart;
        wb_write(32'h4, 32'h0003_0005);
        r0 = req_cnt;
        wb_write(32'h0, 32'h1);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL inv_busy: got %b exp 0", busy); end
        wb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h12) begin n_fail++; $display("FAIL inv_ctrl: got %h exp %h", rd, 32'h12); end
        n_checks++;
        if (delay_code !== 10'd21) begin n_fail++; $display("FAIL inv_code_hold: got %0d exp 21", delay_code); end
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (req_cnt !== r0) begin n_fail++; $display("FAIL inv_pulses: got %0d exp 0", req_cnt - r0); end

        // shots=0 and step=0 behave as 1; writes and START during the sweep are ignored.
        wb_write(32'h4, 32'h0002_0000);
        wb_write(32'h8, 32'h0000_0000);
        r0 = req_cnt;
        wb_write(32'h0, 32'h1);
        wait_code(10'd1, 100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL busy_step1: code=%0d exp 1", delay_code); end
        wb_write(32'h0, 32'h1);
        wb_write(32'h4, 32'h0007_0006);
        wb_write(32'h8, 32'h0001_0005);
        wb_read(32'h4, rd);
        n_checks++;
        if (rd !== 32'h0002_0000) begin n_fail++; $display("FAIL busy_range_wr: got %h exp %h", rd, 32'h00020000); end
        wb_read(32'h8, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL busy_cfg_wr: got %h exp 0", rd); end
        wait_idle(300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL busy_timeout: busy still %b, exp 0", busy); end
        n_checks++;
        if (req_cnt - r0 !== 3) begin n_fail++; $display("FAIL busy_pulses: got %0d exp 3", req_cnt - r0); end
        for (int k = 0; k <= 3; k++) begin
            wb_read(32'hC, rd);
            n_checks++;
            if (rd !== ((k == 3) ? 32'h0 : (32'h8000_0001 | (k << 16)))) begin
                n_fail++;
                $display("FAIL busy_res%0d: got %h exp %h", k, rd,
                         (k == 3) ? 32'h0 : (32'h80000001 | (k << 16)));
            end
        end
    endtask

    task automatic test_back_to_back;
        wb_write(32'h4, 32'h0003_0001);
        wb_write(32'h8, 32'h0002_0005);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = 32'h4;
        @(posedge clk); #1;
        n_checks++;
        if (wb.wb_ack_o !== 1'b1 || wb.wb_dat_o !== 32'h0003_0001) begin
            n_fail++; $display("FAIL b2b_rd0: ack=%b dat=%h exp 1 %h", wb.wb_ack_o, wb.wb_dat_o, 32'h00030001);
        end
        wb.wb_adr_i = 32'h8;
        @(posedge clk); #1;
        n_checks++;
        if (wb.wb_ack_o !== 1'b1 || wb.wb_dat_o !== 32'h0002_0005) begin
            n_fail++; $display("FAIL b2b_rd1: ack=%b dat=%h exp 1 %h", wb.wb_ack_o, wb.wb_dat_o, 32'h00020005);
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (wb.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_drop: got %b exp 0", wb.wb_ack_o); end
    endtask

    task automatic test_reset_mid;
        wb_write(32'h4, 32'h0003_0000);
        wb_write(32'h8, 32'h0001_0001);
        wb_write(32'h0, 32'h1);
        wait_code(10'd1, 100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rstmid_step1: code=%0d exp 1", delay_code); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || stb_req !== 1'b0 || delay_code !== 10'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: busy=%b req=%b code=%0d exp 0 0 0", busy, stb_req, delay_code);
        end
        rst = 1'b0;
        r0 = req_cnt;
        wb_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h10) begin n_fail++; $display("FAIL rstmid_ctrl: got %h exp %h", rd, 32'h10); end
        wb_read(32'h4, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_range: got %h exp 0", rd); end
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (req_cnt !== r0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d pulses exp 0", req_cnt - r0); end
    endtask

    initial begin
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = '0;   wb.wb_dat_i = '0;   wb.wb_sel_i = 4'hf;
        test_reset();
        test_basic_sweep();
        test_top_range();
        test_timeout();
        test_backpressure();
        test_abort();
        test_inverted_and_restart();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/measure_sweep_ctrl.md
MEASURE_SWEEP_CTRL -- requirements
Module: measure_sweep_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 10, delay-code width.
REQ-002 SHALL have parameter CNT_W, default 16, hit-counter and shot-count width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, result FIFO entries (power of 2).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 8, wait after each code change before firing.
REQ-005 SHALL have parameter STB_TIMEOUT, default 1024, maximum cycles to wait for stb_done_i.
REQ-006 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-007 SHALL have the following ports (name, direction, width, meaning):
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone classic/pipelined slave controls
- wb_adr_i  in  32  byte address; only [3:2] decoded
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte selects; ignored, full-word access only
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  transfer acknowledge
- wb_stall_o  out  1  tied 0
- delay_code_o  out  CODE_W  code applied to both delay lines
- stb_req_o  out  1  one-cycle request to the strobe generator
- stb_done_i  in  1  one-cycle pulse when the strobe has fired and comparators have settled
- cmp_i  in  1  synchronised comparator output, sampled on stb_done_i
- busy_o  out  1  sweep in progress
- irq_o  out  1  level; high while DONE or ERR is set and IRQ_EN=1

Function
REQ-010 SHALL ack every access with stb&cyc exactly one cycle later; SHALL accept back-to-back accesses.
REQ-011 SHALL decode registers by adr[3:2]:
- 0 CTRL: write [0]=START, [1]=ABORT, [2]=CLR_FLAGS (self-clearing), [3]=IRQ_EN. Read [0]=busy, [1]=DONE, [2]=ERR, [3]=IRQ_EN, [4]=fifo_empty, [5]=fifo_full.
- 1 RANGE: [CODE_W-1:0]=start_code, [16+CODE_W-1:16]=stop_code.
- 2 CFG: [CNT_W-1:0]=shots per step, [23:16]=step.
- 3 RESULT: read only; pops the FIFO.
REQ-012 SHALL ignore writes to RANGE and CFG while busy.
REQ-013 SHALL treat shots=0 as 1 and step=0 as 1.
REQ-014 SHALL implement the FSM states IDLE, SETTLE, FIRE, WAIT, STORE, NEXT.
REQ-015 IDLE: START=1 SHALL load code=start_code, clear DONE and ERR, go to SETTLE; if start_code>stop_code, SHALL instead set DONE and stay in IDLE.
REQ-016 SETTLE: SHALL drive delay_code_o=code, clear hit and shot counters, count SETTLE_CYCLES, then go to FIRE.
REQ-017 FIRE: SHALL assert stb_req_o for exactly one cycle, then go to WAIT.
REQ-018 WAIT: on stb_done_i SHALL increment shot and add cmp_i to hit; then go to FIRE if shot<shots, else to STORE.
REQ-019 WAIT: after STB_TIMEOUT cycles without stb_done_i SHALL set ERR, discard the partial step, and go to IDLE.
REQ-020 STORE: SHALL push {1'b1, code, hit} to the FIFO when not full, then go to NEXT; when full SHALL hold in STORE (back-pressure, no data loss).
REQ-021 NEXT: SHALL compute code+step at CODE_W+1 bits; if the result >stop_code or the carry is set, SHALL set DONE and go to IDLE, else load code and go to SETTLE.
REQ-022 SHALL saturate hit at 2^CNT_W-1.
REQ-023 ABORT SHALL go to IDLE on the next cycle from any state; stb_req_o SHALL be 0 that cycle; FIFO contents SHALL be retained; DONE SHALL not be set.
REQ-024 START while busy SHALL be ignored; START and ABORT set together SHALL act as ABORT.
REQ-025 RESULT read format: [31]=valid, [16+CODE_W-1:16]=code, [CNT_W-1:0]=hit.
REQ-026 RESULT read on an empty FIFO SHALL return 0 and SHALL not pop.
REQ-027 A simultaneous push and pop SHALL both take effect with the count unchanged.
REQ-028 delay_code_o SHALL hold its last value in IDLE.
REQ-029 busy_o SHALL be 1 in every state except IDLE.
REQ-030 CLR_FLAGS SHALL clear DONE and ERR; a flag set in the same cycle SHALL win.

Reset
REQ-040 On wb_rst_i SHALL return to IDLE and drive these outputs to 0: delay_code_o, stb_req_o, busy_o, irq_o, wb_ack_o, wb_dat_o.
REQ-041 On wb_rst_i SHALL clear DONE, ERR, IRQ_EN, the FIFO, and all counters.
REQ-042 On wb_rst_i SHALL set RANGE and CFG to 0.
REQ-043 Reset asserted mid-sweep SHALL abort with no FIFO push and no stb_req_o in the following cycle.

Verification
REQ-050 RANGE={stop=4,start=2}, CFG={step=1,shots=3}, cmp_i=1 on all shots -> results (code,hit) = (2,3),(3,3),(4,3); DONE=1; 9 stb_req_o pulses.
REQ-051 start=1020, stop=1023, step=8 -> one result at code 1020, then DONE (no wrap to low codes).
REQ-052 stb_done_i never returned -> ERR=1 after 1024 WAIT cycles; irq_o=1 if IRQ_EN=1; FIFO stays empty.
REQ-053 FIFO_DEPTH=4 with 6 steps and no reads -> FSM holds in STORE, busy_o=1; draining 2 entries -> completes with all 6 results in order.
REQ-054 ABORT during WAIT -> IDLE next cycle, busy_o=0, earlier results remain readable; RESULT read when empty -> 0x00000000.
REQ-055 start=5, stop=3 -> DONE immediately, no stb_req_o; START while busy -> no effect on code sequence.
